// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, x/y raster counters, sync decode and a
// one-pixel output stage that registers the blanked colour together with the syncs.
module vga_sync_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] pix_red_in,
    input  logic [2:0] pix_green_in,
    input  logic [1:0] pix_blue_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pixel_tick,
    output logic       endofframe,
    output logic       frame_tick,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] vga_red,
    output logic [2:0] vga_green,
    output logic [1:0] vga_blue
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
    localparam logic [9:0] HDisp   = 10'(H_DISPLAY);
    localparam logic [9:0] HsStart = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HsEnd   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
    localparam logic [9:0] VDisp   = 10'(V_DISPLAY);
    localparam logic [9:0] VDispM1 = 10'(V_DISPLAY - 1);
    localparam logic [9:0] VsStart = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VsEnd   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    // Divider needs at least one bit even when CLK_DIV=1 (tick then stays high).
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic            x_wrap;
    logic            hs_raw, vs_raw, active;
    logic            eof_q, eof_d;
    logic            ft_q, ft_d;
    logic            hsync_q, vsync_q;
    logic [2:0]      red_q, red_d;
    logic [2:0]      green_q, green_d;
    logic [1:0]      blue_q, blue_d;

    assign pixel_tick = (div_q == DivLast);

    // Next-state for divider, raster counters, strobes, and the blanked colour.
    always_comb begin
        div_d   = (div_q == DivLast) ? '0 : div_q + 1'b1;
        x_wrap  = (x_q == HLast);
        x_d     = x_wrap ? 10'd0 : x_q + 10'd1;
        y_d     = y_q;
        if (x_wrap) begin
            y_d = (y_q == VLast) ? 10'd0 : y_q + 10'd1;
        end
        hs_raw  = !((x_q >= HsStart) && (x_q < HsEnd));
        vs_raw  = !((y_q >= VsStart) && (y_q < VsEnd));
        active  = (x_q < HDisp) && (y_q < VDisp);
        eof_d   = (y_d >= VDisp);
        // Only the tick edge that carries y from the last visible line into blanking.
        ft_d    = pixel_tick && x_wrap && (y_q == VDispM1);
        red_d   = active ? pix_red_in   : 3'd0;
        green_d = active ? pix_green_in : 3'd0;
        blue_d  = active ? pix_blue_in  : 2'd0;
    end

    // Free-running clock divider producing the pixel rate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Raster counters and vertical-blanking flag, advanced once per pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= 10'd0;
            y_q   <= 10'd0;
            eof_q <= 1'b0;
        end else if (pixel_tick) begin
            x_q   <= x_d;
            y_q   <= y_d;
            eof_q <= eof_d;
        end
    end

    // Single-clock frame strobe, registered every clock so it self-clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ft_q <= 1'b0;
        end else begin
            ft_q <= ft_d;
        end
    end

    // Output stage: syncs and colour delayed together by one pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            red_q   <= 3'd0;
            green_q <= 3'd0;
            blue_q  <= 2'd0;
        end else if (pixel_tick) begin
            hsync_q <= hs_raw;
            vsync_q <= vs_raw;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign endofframe = eof_q;
    assign frame_tick = ft_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign vga_red    = red_q;
    assign vga_green  = green_q;
    assign vga_blue   = blue_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a reduced-size instance (fast frames) and a default-size instance
// run side by side against a closed-form timing model through a scoreboard queue, plus a
// checkpoint table and hand-written corner sequences.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       tick;
        logic       eof;
        logic       ft;
        logic       hs;
        logic       vs;
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } out_t;

    typedef struct packed {
        int unsigned hd, hf, hsw, hb, vd, vf, vsw, vb;
    } cfg_t;

    typedef struct {
        int unsigned n;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        tick, hs, vs, eof, ft;
    } vec_t;

    localparam cfg_t CfgS = '{hd: 16, hf: 4, hsw: 6, hb: 4, vd: 12, vf: 2, vsw: 2, vb: 3};
    localparam cfg_t CfgF = '{hd: 640, hf: 16, hsw: 96, hb: 48, vd: 480, vf: 10, vsw: 2, vb: 33};
    localparam int NT = 13;

    logic       clk, reset;
    logic [2:0] pr_s, pg_s, pr_f, pg_f;
    logic [1:0] pb_s, pb_f;
    logic [9:0] x_s, y_s, x_f, y_f;
    logic       tick_s, eof_s, ft_s, hs_s, vs_s;
    logic       tick_f, eof_f, ft_f, hs_f, vs_f;
    logic [2:0] r_s, g_s, r_f, g_f;
    logic [1:0] b_s, b_f;
    out_t       got_s, got_f;

    int          total, bad;
    int unsigned n;
    out_t        prev_s, prev_f;
    out_t        q_s[$], q_f[$];
    logic        ones;
    int          phase;
    vec_t        tbl[NT];
    int          tix;
    int unsigned ft_cnt, vs_low_s, hs_low_s, hs_low_f, first_hs_f, eof_rise;
    logic        eof_prev;

    vga_sync_gen #(
        .H_DISPLAY(CfgS.hd), .H_FRONT(CfgS.hf), .H_SYNC(CfgS.hsw), .H_BACK(CfgS.hb),
        .V_DISPLAY(CfgS.vd), .V_FRONT(CfgS.vf), .V_SYNC(CfgS.vsw), .V_BACK(CfgS.vb),
        .CLK_DIV(2)
    ) u_dut_s (
        .clk(clk), .reset(reset),
        .pix_red_in(pr_s), .pix_green_in(pg_s), .pix_blue_in(pb_s),
        .x(x_s), .y(y_s), .pixel_tick(tick_s), .endofframe(eof_s), .frame_tick(ft_s),
        .hsync(hs_s), .vsync(vs_s), .vga_red(r_s), .vga_green(g_s), .vga_blue(b_s)
    );

    vga_sync_gen u_dut_f (
        .clk(clk), .reset(reset),
        .pix_red_in(pr_f), .pix_green_in(pg_f), .pix_blue_in(pb_f),
        .x(x_f), .y(y_f), .pixel_tick(tick_f), .endofframe(eof_f), .frame_tick(ft_f),
        .hsync(hs_f), .vsync(vs_f), .vga_red(r_f), .vga_green(g_f), .vga_blue(b_f)
    );

    assign got_s = {x_s, y_s, tick_s, eof_s, ft_s, hs_s, vs_s, r_s, g_s, b_s};
    assign got_f = {x_f, y_f, tick_f, eof_f, ft_f, hs_f, vs_f, r_f, g_f, b_f};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int unsigned htot(input cfg_t c);
        return c.hd + c.hf + c.hsw + c.hb;
    endfunction

    function automatic int unsigned vtot(input cfg_t c);
        return c.vd + c.vf + c.vsw + c.vb;
    endfunction

    function automatic out_t rst_out();
        out_t o;
        o    = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    // Outputs after nn clock edges since reset release (CLK_DIV=2: pixel p = nn/2).
    function automatic out_t predict(input int unsigned nn, input logic [2:0] r,
                                     input logic [2:0] g, input logic [1:0] b,
                                     input out_t prev, input cfg_t c);
        out_t o;
        int unsigned ht, vt, p, xc, yc, xq, yq;
        if (nn == 0) return rst_out();
        ht     = htot(c);
        vt     = vtot(c);
        p      = nn / 2;
        xc     = p % ht;
        yc     = (p / ht) % vt;
        o      = prev;
        o.x    = 10'(xc);
        o.y    = 10'(yc);
        o.tick = (nn % 2 == 1);
        o.eof  = (yc >= c.vd);
        o.ft   = (nn % 2 == 0) && (xc == 0) && (yc == c.vd);
        if (nn % 2 == 0) begin
            xq   = (p - 1) % ht;
            yq   = ((p - 1) / ht) % vt;
            o.hs = !((xq >= c.hd + c.hf) && (xq < c.hd + c.hf + c.hsw));
            o.vs = !((yq >= c.vd + c.vf) && (yq < c.vd + c.vf + c.vsw));
            if (xq < c.hd && yq < c.vd) begin
                o.r = r;
                o.g = g;
                o.b = b;
            end else begin
                o.r = 3'd0;
                o.g = 3'd0;
                o.b = 2'd0;
            end
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at n=%0d: got %0h required %0h", name, n, got, exp);
        end
    endtask

    // One clock: drive at negedge, push prediction, compare #1 after posedge.
    task automatic step(input logic rst_v);
        out_t        es, ef, gs, gf;
        int unsigned nn, p, xs, ys, xf, yf;
        @(negedge clk);
        if (rst_v && !reset) begin
            reset = 1'b1;
            #1;
            check("async_reset_small", 64'(got_s), 64'(rst_out()));
            check("async_reset_full", 64'(got_f), 64'(rst_out()));
        end
        reset = rst_v;
        nn    = rst_v ? 0 : n + 1;
        p     = rst_v ? 0 : n / 2;
        xs    = p % htot(CfgS);
        ys    = (p / htot(CfgS)) % vtot(CfgS);
        xf    = p % htot(CfgF);
        yf    = (p / htot(CfgF)) % vtot(CfgF);
        pr_s  = ones ? 3'h7 : 3'(xs);
        pg_s  = ones ? 3'h7 : 3'(ys);
        pb_s  = ones ? 2'h3 : 2'($urandom);
        pr_f  = ones ? 3'h7 : 3'(xf);
        pg_f  = ones ? 3'h7 : 3'(yf);
        pb_f  = ones ? 2'h3 : 2'($urandom);
        es    = predict(nn, pr_s, pg_s, pb_s, prev_s, CfgS);
        ef    = predict(nn, pr_f, pg_f, pb_f, prev_f, CfgF);
        q_s.push_back(es);
        q_f.push_back(ef);
        prev_s = es;
        prev_f = ef;
        @(posedge clk);
        #1;
        n  = nn;
        gs = q_s.pop_front();
        gf = q_f.pop_front();
        check("sb_small", 64'(got_s), 64'(gs));
        check("sb_full", 64'(got_f), 64'(gf));
        if (ft_s) ft_cnt++;
        if (!vs_s) vs_low_s++;
        if (!hs_s) hs_low_s++;
        if (!hs_f) begin
            hs_low_f++;
            if (first_hs_f == 0) first_hs_f = n;
        end
        if (eof_s && !eof_prev && eof_rise == 0) eof_rise = n;
        eof_prev = eof_s;
        if (phase == 1 && tix < NT && tbl[tix].n == n) begin
            check("table", 64'({x_s, y_s, tick_s, hs_s, vs_s, eof_s, ft_s}),
                  64'({tbl[tix].x, tbl[tix].y, tbl[tix].tick, tbl[tix].hs, tbl[tix].vs,
                       tbl[tix].eof, tbl[tix].ft}));
            tix++;
        end
        if (phase == 2 && (n == 1142 || n == 1832)) check("blank_corner_on", 64'({r_s, g_s, b_s}), 64'hFF);
        if (phase == 2 && n == 1834) check("blank_corner_off", 64'({r_s, g_s, b_s}), 64'h0);
    endtask

    initial begin
        bool_init();
    end

    task automatic clear_stats();
        ft_cnt   = 0;
        vs_low_s = 0;
        hs_low_s = 0;
        eof_rise = 0;
        eof_prev = 1'b0;
    endtask

    task automatic bool_init();
        logic found;
        // Checkpoints for the reduced instance: {n, x, y, tick, hs, vs, eof, ft}.
        tbl[0]  = '{0,    10'd0,  10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1,    10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{2,    10'd1,  10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{40,   10'd20, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{42,   10'd21, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{52,   10'd26, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{54,   10'd27, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{60,   10'd0,  10'd1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{720,  10'd0,  10'd12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{721,  10'd0,  10'd12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{842,  10'd1,  10'd14, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{962,  10'd1,  10'd16, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1140, 10'd0,  10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        total      = 0;
        bad        = 0;
        n          = 0;
        ones       = 1'b0;
        phase      = 1;
        tix        = 0;
        hs_low_f   = 0;
        first_hs_f = 0;
        prev_s     = rst_out();
        prev_f     = rst_out();
        reset      = 1'b1;
        pr_s = '0; pg_s = '0; pb_s = '0; pr_f = '0; pg_f = '0; pb_f = '0;
        clear_stats();

        // Reset hold, then one full reduced frame with pix_red/green = x/y.
        for (int i = 0; i < 5; i++) step(1'b1);
        for (int i = 0; i < 1140; i++) step(1'b0);
        check("table_coverage", 64'(tix), 64'(NT));
        check("frame_tick_per_frame", 64'(ft_cnt), 64'd1);
        check("vsync_low_clks", 64'(vs_low_s), 64'd120);
        check("hsync_low_clks_small", 64'(hs_low_s), 64'd228);

        // Constant all-ones colour: blanking and active-area corners.
        phase = 2;
        ones  = 1'b1;
        for (int i = 0; i < 860; i++) step(1'b0);
        check("hsync_fall_full", 64'(first_hs_f), 64'd1314);
        check("hsync_width_full", 64'(hs_low_f), 64'd192);

        // Reset while the reduced instance sits in vertical blanking (y=15).
        phase = 3;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (((n / 2) / htot(CfgS)) % vtot(CfgS) == 15) found = 1'b1;
            else step(1'b0);
        end
        check("reach_vblank", 64'({found, y_s, eof_s}), 64'({1'b1, 10'd15, 1'b1}));
        clear_stats();
        for (int i = 0; i < 5; i++) step(1'b1);
        check("no_frame_tick_in_reset", 64'(ft_cnt), 64'd0);
        clear_stats();
        for (int i = 0; i < 760; i++) step(1'b0);
        check("eof_rise_after_reset", 64'(eof_rise), 64'd720);
        check("frame_tick_after_reset", 64'(ft_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA timing from the 50 MHz system clock. Feeds pixel coordinates to the paddle and ball graphics blocks, and the `endofframe` strobe to the paddle and ball movement blocks. Registers the muxed pixel colour coming back from those blocks and blanks it outside the active area. Drives the VGA connector directly.

## Interface
Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (≥1)

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  reset, asynchronous, active-high
- pix_red_in / pix_green_in  in  3 each  colour from the pixel mux for the current x,y
- pix_blue_in  in  2  colour from the pixel mux
- x  out  10  horizontal counter; active area is 0..H_DISPLAY-1
- y  out  10  vertical counter; active area is 0..V_DISPLAY-1
- pixel_tick  out  1  one-clk pulse per pixel
- endofframe  out  1  high while y ≥ V_DISPLAY (vertical blanking)
- frame_tick  out  1  one-clk pulse when y enters V_DISPLAY
- hsync / vsync  out  1 each  active-low syncs, delayed to align with the RGB outputs
- vga_red / vga_green  out  3 each  registered, blanked colour
- vga_blue  out  2  registered, blanked colour

## Operation
- Divider:
  - `div` counts 0..CLK_DIV-1 and wraps.
  - `pixel_tick` = (div == CLK_DIV-1), decoded from the register.
  - With CLK_DIV=1, `pixel_tick` is constantly high.
- Counters (H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = 525). All updates occur only on clk edges where `pixel_tick`=1.
  - `x` increments and wraps H_TOTAL-1 → 0.
  - On that wrap, `y` increments and wraps V_TOTAL-1 → 0.
- Sync decode, from the current counters:
  - hs_raw low when H_DISPLAY+H_FRONT ≤ x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vs_raw low when y is in 490..491.
  - active = (x < H_DISPLAY) && (y < V_DISPLAY).
- Output pipeline, one pixel stage, loaded on `pixel_tick`:
  - hsync ← hs_raw, vsync ← vs_raw.
  - vga_* ← active ? pix_*_in : 0.
  - Colour and syncs therefore leave together, one pixel after the matching x,y.
- `endofframe` is a register loaded on `pixel_tick` with (y_next ≥ V_DISPLAY). It rises on the same edge that y becomes V_DISPLAY and falls on the edge that y wraps to 0. The movement blocks clock on its rising edge, once per frame.
- `frame_tick` is a one-clk pulse on the edge where y becomes V_DISPLAY, coincident with `endofframe` rising. It is 0 on every other cycle.
- Width rules:
  - Counters are 10-bit unsigned; all compares are unsigned.
  - Parameter sums must fit in 10 bits; this is not checked in RTL.

## Timing
- Reset values, held while reset=1 and set asynchronously:
  - div=0, x=0, y=0, pixel_tick=0.
  - endofframe=0, frame_tick=0.
  - hsync=1, vsync=1, vga_*=0.
- First `pixel_tick` arrives CLK_DIV-1 clks after reset deasserts (1 clk for CLK_DIV=2). x becomes 1 on the following edge.
- Latency from x,y to vga_*/hsync/vsync is exactly 1 pixel, i.e. CLK_DIV clks.
- Line period = 800 pixels (1600 clks); frame period = 420000 pixels.
- The hsync low pulse lasts exactly 96 pixels. The vsync low pulse lasts exactly 2 lines.
- Simultaneous x wrap and y wrap (x=799, y=524): both go to 0 on the same edge. `endofframe` falls on that edge.
- Reset asserted mid-frame:
  - All state returns to reset values immediately, with no partial pulse on frame_tick.
  - After release, counting restarts at (0,0). endofframe stays 0 until y reaches 480 again.
- Inputs pix_*_in are sampled only on `pixel_tick` edges. They must be stable in the clk before the tick.

## Test plan
- Reset: hold reset 5 clks mid-count → all outputs at reset values. After release, pixel_tick period is 2 clks, and x=1 appears 2 clks after release.
- Horizontal: run one line → hsync goes low when delayed x=656 (pipeline-aligned), stays low 96 pixels, and the line wraps after 800 pixels.
- Vertical/frame: run a full frame →
  - endofframe rises with y=480 and falls at the y wrap to 0.
  - frame_tick pulses exactly once per 840000 clks.
  - vsync is low for exactly 1600 pixels (2 lines) starting at line 490.
- Blanking: drive pix_* = 3'b111/3'b111/2'b11 constantly →
  - vga_* are 0 whenever delayed x ≥ 640 or y ≥ 480.
  - vga_* are all-ones at delayed (0,0) and (639,479).
- Pipeline alignment: drive pix_red_in = x[2:0] → vga_red equals the x value from 1 pixel earlier, every active pixel.
- Reset during vertical blanking (y=500): endofframe drops to 0 asynchronously with no frame_tick. The next endofframe rise occurs exactly 480 lines after release.
